// File: rtl/mips_min_sopc_pkg.sv
// ---------------------------------------------------------------------------
// mips_min_sopc_pkg
// Shared definitions for the minimal MIPS32 SoC: reset level, bus widths,
// opcode/funct encodings of the supported logic subset, the ALU operation
// enum and the ALU evaluation function used by the execute stage.
// ---------------------------------------------------------------------------
package mips_min_sopc_pkg;

    localparam logic RST_ENABLE = 1'b1;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;
    localparam int REG_W       = 32;
    localparam int REG_ADDR_W  = 5;
    localparam int REG_NUM     = 32;

    // Register $0: reads as zero, and doubles as "no destination" in the pipe.
    localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = '0;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;

    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_XOR  = 6'h26;
    localparam logic [5:0] FUNCT_NOR  = 6'h27;

    typedef enum logic [2:0] {
        ALU_NOP = 3'd0,
        ALU_OR  = 3'd1,
        ALU_AND = 3'd2,
        ALU_XOR = 3'd3,
        ALU_NOR = 3'd4,
        ALU_LUI = 3'd5
    } alu_op_e;

    // For LUI the decoder already places imm16 in the upper half of src2.
    function automatic logic [REG_W-1:0] alu_calc(input alu_op_e op,
                                                  input logic [REG_W-1:0] src1,
                                                  input logic [REG_W-1:0] src2);
        logic [REG_W-1:0] res;
        case (op)
            ALU_OR:  res = src1 | src2;
            ALU_AND: res = src1 & src2;
            ALU_XOR: res = src1 ^ src2;
            ALU_NOR: res = ~(src1 | src2);
            ALU_LUI: res = src2;
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mips_min_sopc_core.sv
// ---------------------------------------------------------------------------
// mips_core
// Five-stage in-order MIPS32 pipeline (IF/ID/EX/MEM/WB) with a 32x32
// register file, executing ORI/ANDI/XORI/LUI and SPECIAL AND/OR/XOR/NOR.
// Operands are forwarded from EX and MEM into ID; the register file
// bypasses the WB write, so dependent instructions never stall.
// Ports:
//   clk        system clock, all state on posedge
//   rst        asynchronous active-high reset, flushes every stage
//   inst       instruction word from the external ROM
//   rom_ce     ROM chip enable, 0 while in reset
//   inst_addr  byte fetch address (PC)
// wb_wd_i / wb_wdata_i are the MEM/WB register outputs, kept as named
// signals for debug visibility; wb_wd_i is zero whenever nothing is written.
// ---------------------------------------------------------------------------
module mips_core
    import mips_min_sopc_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INST_W-1:0]      inst,
    output logic                   rom_ce,
    output logic [INST_ADDR_W-1:0] inst_addr
);

    logic [INST_ADDR_W-1:0] pc;
    logic [INST_W-1:0]      inst_p0;

    alu_op_e                id_alu_op;
    logic [REG_ADDR_W-1:0]  id_wd;
    logic                   id_vld;
    logic [REG_W-1:0]       id_imm;
    logic                   id_use_imm;
    logic [REG_W-1:0]       id_reg1;
    logic [REG_W-1:0]       id_reg2;

    alu_op_e                alu_op_p1;
    logic [REG_W-1:0]       src1_p1;
    logic [REG_W-1:0]       src2_p1;
    logic [REG_ADDR_W-1:0]  wd_p1;
    logic                   vld_p1;
    logic [REG_W-1:0]       ex_wdata;

    logic [REG_ADDR_W-1:0]  wd_p2;
    logic [REG_W-1:0]       wdata_p2;
    logic                   vld_p2;

    logic [REG_ADDR_W-1:0]  wd_p3;
    logic [REG_W-1:0]       wdata_p3;
    logic                   vld_p3;

    logic [REG_ADDR_W-1:0]  wb_wd_i;
    logic [REG_W-1:0]       wb_wdata_i;

    logic [REG_W-1:0]       gpr [REG_NUM];

    logic [5:0]             op;
    logic [5:0]             funct;
    logic [REG_ADDR_W-1:0]  rs;
    logic [REG_ADDR_W-1:0]  rt;
    logic [REG_ADDR_W-1:0]  rd;
    logic [4:0]             shamt;
    logic [15:0]            imm;

    assign inst_addr  = pc;
    assign wb_wd_i    = wd_p3;
    assign wb_wdata_i = wdata_p3;

    // ---- IF: PC holds 0 until the cycle after rom_ce rises ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            rom_ce <= 1'b0;
            pc     <= '0;
        end else begin
            rom_ce <= 1'b1;
            pc     <= rom_ce ? pc + 32'd4 : '0;
        end
    end

    // ---- IF/ID ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            inst_p0 <= '0;
        end else begin
            inst_p0 <= rom_ce ? inst : '0;
        end
    end

    // ---- ID: decode ----
    assign op    = inst_p0[31:26];
    assign rs    = inst_p0[25:21];
    assign rt    = inst_p0[20:16];
    assign rd    = inst_p0[15:11];
    assign shamt = inst_p0[10:6];
    assign funct = inst_p0[5:0];
    assign imm   = inst_p0[15:0];

    always_comb begin
        id_alu_op  = ALU_NOP;
        id_wd      = NOP_REG_ADDR;
        id_use_imm = 1'b0;
        id_imm     = {16'h0000, imm};
        case (op)
            OP_ORI:  begin id_alu_op = ALU_OR;  id_wd = rt; id_use_imm = 1'b1; end
            OP_ANDI: begin id_alu_op = ALU_AND; id_wd = rt; id_use_imm = 1'b1; end
            OP_XORI: begin id_alu_op = ALU_XOR; id_wd = rt; id_use_imm = 1'b1; end
            OP_LUI: begin
                id_alu_op  = ALU_LUI;
                id_wd      = rt;
                id_use_imm = 1'b1;
                id_imm     = {imm, 16'h0000};
            end
            OP_SPECIAL: begin
                if (shamt == 5'd0) begin
                    case (funct)
                        FUNCT_AND: begin id_alu_op = ALU_AND; id_wd = rd; end
                        FUNCT_OR:  begin id_alu_op = ALU_OR;  id_wd = rd; end
                        FUNCT_XOR: begin id_alu_op = ALU_XOR; id_wd = rd; end
                        FUNCT_NOR: begin id_alu_op = ALU_NOR; id_wd = rd; end
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase
        // A write to $0 is dropped here so the rest of the pipe only ever
        // carries wd != 0 together with a valid write.
        if (id_alu_op == ALU_NOP || id_wd == NOP_REG_ADDR) begin
            id_alu_op = ALU_NOP;
            id_wd     = NOP_REG_ADDR;
        end
        id_vld = (id_alu_op != ALU_NOP);
    end

    // Operand priority: EX result, MEM result, WB bypass, then the array.
    always_comb begin
        id_reg1 = gpr[rs];
        if (rs == NOP_REG_ADDR)                 id_reg1 = '0;
        else if (vld_p1 && wd_p1 == rs)         id_reg1 = ex_wdata;
        else if (vld_p2 && wd_p2 == rs)         id_reg1 = wdata_p2;
        else if (vld_p3 && wb_wd_i == rs)       id_reg1 = wb_wdata_i;
    end

    always_comb begin
        id_reg2 = gpr[rt];
        if (rt == NOP_REG_ADDR)                 id_reg2 = '0;
        else if (vld_p1 && wd_p1 == rt)         id_reg2 = ex_wdata;
        else if (vld_p2 && wd_p2 == rt)         id_reg2 = wdata_p2;
        else if (vld_p3 && wb_wd_i == rt)       id_reg2 = wb_wdata_i;
    end

    // ---- ID/EX ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            alu_op_p1 <= ALU_NOP;
            src1_p1   <= '0;
            src2_p1   <= '0;
            wd_p1     <= '0;
            vld_p1    <= 1'b0;
        end else begin
            alu_op_p1 <= id_alu_op;
            src1_p1   <= id_reg1;
            src2_p1   <= id_use_imm ? id_imm : id_reg2;
            wd_p1     <= id_wd;
            vld_p1    <= id_vld;
        end
    end

    // ---- EX ----
    assign ex_wdata = alu_calc(alu_op_p1, src1_p1, src2_p1);

    // ---- EX/MEM ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            wd_p2    <= '0;
            wdata_p2 <= '0;
            vld_p2   <= 1'b0;
        end else begin
            wd_p2    <= wd_p1;
            wdata_p2 <= ex_wdata;
            vld_p2   <= vld_p1;
        end
    end

    // ---- MEM/WB (MEM stage is a pass-through: no data memory) ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            wd_p3    <= '0;
            wdata_p3 <= '0;
            vld_p3   <= 1'b0;
        end else begin
            wd_p3    <= wd_p2;
            wdata_p3 <= wdata_p2;
            vld_p3   <= vld_p2;
        end
    end

    // ---- WB: register file write ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            for (int i = 0; i < REG_NUM; i++) begin
                gpr[i] <= '0;
            end
        end else if (vld_p3 && wb_wd_i != NOP_REG_ADDR) begin
            gpr[wb_wd_i] <= wb_wdata_i;
        end
    end

endmodule

// File: rtl/mips_min_sopc.sv
// ---------------------------------------------------------------------------
// mips_min_sopc
// Minimal MIPS32 SoC top: wraps the pipeline core (openmips0). The
// instruction ROM is external and combinational.
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   rom_ce     ROM chip enable, 0 while in reset
//   inst_addr  byte fetch address; the ROM indexes word address [31:2]
//   inst       instruction word returned by the ROM
// ---------------------------------------------------------------------------
module mips_min_sopc
    import mips_min_sopc_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    output logic                   rom_ce,
    output logic [INST_ADDR_W-1:0] inst_addr,
    input  logic [INST_W-1:0]      inst
);

    mips_core openmips0 (
        .clk       (clk),
        .rst       (rst),
        .inst      (inst),
        .rom_ce    (rom_ce),
        .inst_addr (inst_addr)
    );

endmodule

// File: tb/tb_mips_min_sopc.sv
module tb_mips_min_sopc;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rom_ce;
    logic [31:0] inst_addr;
    logic [31:0] inst;

    logic [31:0] rom [0:255];

    always #5 clk = ~clk;

    assign inst = rom_ce ? rom[inst_addr[9:2]] : 32'h0;

    mips_min_sopc dut (
        .clk       (clk),
        .rst       (rst),
        .rom_ce    (rom_ce),
        .inst_addr (inst_addr),
        .inst      (inst)
    );

    wire [4:0]  wb_wd    = dut.openmips0.wb_wd_i;
    wire [31:0] wb_wdata = dut.openmips0.wb_wdata_i;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected WB stream, indexed by ROM word (program order).
    logic [4:0]  exp_wd    [0:255];
    logic [31:0] exp_wdata [0:255];
    logic [31:0] model_gpr [0:31];

    // Architectural (sequential, no pipeline) model of one instruction.
    task automatic model_step(input logic [31:0] w, output logic [4:0] d, output logic [31:0] v);
        logic [31:0] a, b, zimm;
        a    = model_gpr[w[25:21]];
        b    = model_gpr[w[20:16]];
        zimm = {16'h0, w[15:0]};
        d = 5'd0;
        v = 32'h0;
        case (w[31:26])
            6'h0D: begin d = w[20:16]; v = a | zimm; end
            6'h0C: begin d = w[20:16]; v = a & zimm; end
            6'h0E: begin d = w[20:16]; v = a ^ zimm; end
            6'h0F: begin d = w[20:16]; v = {w[15:0], 16'h0}; end
            6'h00: begin
                if (w[10:6] == 5'd0) begin
                    case (w[5:0])
                        6'h24: begin d = w[15:11]; v = a & b; end
                        6'h25: begin d = w[15:11]; v = a | b; end
                        6'h26: begin d = w[15:11]; v = a ^ b; end
                        6'h27: begin d = w[15:11]; v = ~(a | b); end
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase
        if (d == 5'd0) v = 32'h0;
        else model_gpr[d] = v;
    endtask

    task automatic load_rom(input logic [31:0] prog [$]);
        for (int i = 0; i < 256; i++) rom[i] = 32'h0;
        for (int i = 0; i < prog.size(); i++) rom[i] = prog[i];
    endtask

    task automatic build_expect();
        for (int i = 0; i < 32; i++) model_gpr[i] = 32'h0;
        for (int i = 0; i < 256; i++) model_step(rom[i], exp_wd[i], exp_wdata[i]);
    endtask

    // Expected stream for the four-ORI program, written out by hand.
    task automatic basic_expect();
        for (int i = 0; i < 256; i++) begin exp_wd[i] = 5'd0; exp_wdata[i] = 32'h0; end
        exp_wd[0] = 5'd1; exp_wdata[0] = 32'h0000_1100;
        exp_wd[1] = 5'd2; exp_wdata[1] = 32'h0000_0020;
        exp_wd[2] = 5'd3; exp_wdata[2] = 32'h0000_ff00;
        exp_wd[3] = 5'd4; exp_wdata[3] = 32'h0000_ffff;
    endtask

    // Waits (bounded) for rom_ce; returns the number of posedges taken, 0 on timeout.
    task automatic wait_ce(output int waited);
        waited = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (rom_ce === 1'b1) begin waited = i; break; end
        end
    endtask

    task automatic start_cpu(output int waited);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        wait_ce(waited);
    endtask

    // Advance one cycle; cycle j after rom_ce rose shows program word j-4 in WB.
    task automatic step(input int j, output logic [4:0] ewd, output logic [31:0] ewdata);
        @(posedge clk); #1;
        if (j >= 4) begin ewd = exp_wd[j-4]; ewdata = exp_wdata[j-4]; end
        else begin ewd = 5'd0; ewdata = 32'h0; end
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (rom_ce !== 1'b0) begin n_bad++; $display("FAIL reset_rom_ce: got %b want 0", rom_ce); end
        n_cmp++; if (inst_addr !== 32'h0) begin n_bad++; $display("FAIL reset_pc: got %h want 0", inst_addr); end
        n_cmp++; if (wb_wd !== 5'd0) begin n_bad++; $display("FAIL reset_wb_wd: got %0d want 0", wb_wd); end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (rom_ce !== 1'b0) begin n_bad++; $display("FAIL reset_hold_rom_ce: got %b want 0", rom_ce); end
        n_cmp++; if (inst_addr !== 32'h0) begin n_bad++; $display("FAIL reset_hold_pc: got %h want 0", inst_addr); end
    endtask

    task automatic test_basic();
        logic [31:0] prog [$];
        logic [4:0]  ewd;
        logic [31:0] ewdata;
        int          waited;
        prog = '{32'h34011100, 32'h34020020, 32'h3403ff00, 32'h3404ffff};
        load_rom(prog);
        basic_expect();
        start_cpu(waited);
        n_cmp++; if (waited !== 1) begin n_bad++; $display("FAIL basic_ce_rise: got %0d cycles want 1", waited); end
        n_cmp++; if (inst_addr !== 32'h0) begin n_bad++; $display("FAIL basic_first_pc: got %h want 0", inst_addr); end
        for (int j = 1; j <= 12; j++) begin
            step(j, ewd, ewdata);
            n_cmp++;
            if (inst_addr !== 32'(4 * j)) begin n_bad++; $display("FAIL basic_pc c%0d: got %h want %h", j, inst_addr, 32'(4 * j)); end
            n_cmp++;
            if (wb_wd !== ewd) begin n_bad++; $display("FAIL basic_wd c%0d: got %0d want %0d", j, wb_wd, ewd); end
            if (ewd != 5'd0) begin
                n_cmp++;
                if (wb_wdata !== ewdata) begin n_bad++; $display("FAIL basic_wdata c%0d: got %h want %h", j, wb_wdata, ewdata); end
            end
        end
    endtask

    // Runs the loaded ROM against the architectural model for n cycles.
    task automatic test_program(input string name, input logic [31:0] prog [$], input int n);
        logic [4:0]  ewd;
        logic [31:0] ewdata;
        int          waited;
        load_rom(prog);
        build_expect();
        start_cpu(waited);
        n_cmp++; if (waited !== 1) begin n_bad++; $display("FAIL %s_ce_rise: got %0d cycles want 1", name, waited); end
        for (int j = 1; j <= n; j++) begin
            step(j, ewd, ewdata);
            n_cmp++;
            if (wb_wd !== ewd) begin n_bad++; $display("FAIL %s_wd c%0d: got %0d want %0d", name, j, wb_wd, ewd); end
            if (ewd != 5'd0) begin
                n_cmp++;
                if (wb_wdata !== ewdata) begin n_bad++; $display("FAIL %s_wdata c%0d: got %h want %h", name, j, wb_wdata, ewdata); end
            end
        end
    endtask

    task automatic test_dependency();
        logic [31:0] prog [$];
        prog = '{32'h34011100, 32'h34210101};
        test_program("dep", prog, 8);
        // Hand check of the forwarded result independent of the model.
        n_cmp++; if (exp_wdata[1] !== 32'h0000_1101) begin n_bad++; $display("FAIL dep_model: got %h want 00001101", exp_wdata[1]); end
    endtask

    task automatic test_logic_ops();
        logic [31:0] prog [$];
        prog = '{32'h34011100, 32'h34020020, 32'h00221825, 32'h00222024, 32'h3c05abcd};
        test_program("logic", prog, 10);
    endtask

    task automatic test_nop_zero();
        logic [31:0] prog [$];
        prog = '{32'h00000000, 32'hfc000000, 32'h34000005, 32'h34060007, 32'h00003825};
        test_program("nopz", prog, 10);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [4:0]  rs, rt, rd;
        logic [31:0] w;
        rs = 5'($urandom_range(0, 5));
        rt = 5'($urandom_range(0, 5));
        rd = 5'($urandom_range(0, 5));
        case ($urandom_range(0, 9))
            0: w = {6'h0D, rs, rt, 16'($urandom)};
            1: w = {6'h0C, rs, rt, 16'($urandom)};
            2: w = {6'h0E, rs, rt, 16'($urandom)};
            3: w = {6'h0F, 5'd0, rt, 16'($urandom)};
            4, 5, 6: w = {6'h00, rs, rt, rd, 5'd0, 6'(6'h24 + 6'($urandom_range(0, 3)))};
            7: w = {6'h00, rs, rt, rd, 5'($urandom_range(1, 31)), 6'h25};
            default: w = $urandom;
        endcase
        return w;
    endfunction

    task automatic test_random();
        logic [31:0] prog [$];
        for (int r = 0; r < 4; r++) begin
            prog = {};
            for (int i = 0; i < 40; i++) prog.push_back(rand_inst());
            test_program("rand", prog, 48);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] prog [$];
        logic [4:0]  ewd;
        logic [31:0] ewdata;
        int          waited;
        prog = '{32'h34011100, 32'h34020020, 32'h3403ff00, 32'h3404ffff};
        load_rom(prog);
        basic_expect();
        start_cpu(waited);
        repeat (6) @(posedge clk);
        #1;
        n_cmp++; if (wb_wd !== 5'd3) begin n_bad++; $display("FAIL midrst_inflight: got %0d want 3", wb_wd); end
        @(negedge clk); rst = 1'b1;
        #1;
        n_cmp++; if (rom_ce !== 1'b0) begin n_bad++; $display("FAIL midrst_rom_ce: got %b want 0", rom_ce); end
        n_cmp++; if (inst_addr !== 32'h0) begin n_bad++; $display("FAIL midrst_pc: got %h want 0", inst_addr); end
        n_cmp++; if (wb_wd !== 5'd0) begin n_bad++; $display("FAIL midrst_wb_wd: got %0d want 0", wb_wd); end
        @(posedge clk); #1;
        n_cmp++; if (wb_wd !== 5'd0) begin n_bad++; $display("FAIL midrst_hold_wd: got %0d want 0", wb_wd); end
        @(negedge clk); rst = 1'b0;
        wait_ce(waited);
        n_cmp++; if (waited !== 1) begin n_bad++; $display("FAIL midrst_ce_rise: got %0d cycles want 1", waited); end
        n_cmp++; if (inst_addr !== 32'h0) begin n_bad++; $display("FAIL midrst_restart_pc: got %h want 0", inst_addr); end
        for (int j = 1; j <= 10; j++) begin
            step(j, ewd, ewdata);
            n_cmp++;
            if (inst_addr !== 32'(4 * j)) begin n_bad++; $display("FAIL midrst_pc c%0d: got %h want %h", j, inst_addr, 32'(4 * j)); end
            n_cmp++;
            if (wb_wd !== ewd) begin n_bad++; $display("FAIL midrst_wd c%0d: got %0d want %0d", j, wb_wd, ewd); end
            if (ewd != 5'd0) begin
                n_cmp++;
                if (wb_wdata !== ewdata) begin n_bad++; $display("FAIL midrst_wdata c%0d: got %h want %h", j, wb_wdata, ewdata); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_dependency();
        test_logic_ops();
        test_nop_zero();
        test_random();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
